// File: rtl/fft_top_div_pkg.sv
// -----------------------------------------------------------------------------
// fft_top_div_pkg
// Shared definitions for the sequential signed divider used beside the FFT
// multiplier stages: FSM state encoding, default operand widths and the
// quotient saturation constants.
// -----------------------------------------------------------------------------
package fft_top_div_pkg;

  localparam int DEF_DIVIDEND_WIDTH = 35;
  localparam int DEF_DIVISOR_WIDTH  = 15;
  localparam int DEF_QUOTIENT_WIDTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Largest positive quotient, +2^(qw-1)-1, right-aligned in 64 bits.
  function automatic logic [63:0] qmax(input int qw);
    qmax = (64'd1 << (qw - 1)) - 64'd1;
  endfunction

  // Most negative quotient, -2^(qw-1), two's complement in 64 bits.
  // The low qw bits also read as the unsigned magnitude 2^(qw-1).
  function automatic logic [63:0] qmin(input int qw);
    qmin = ~((64'd1 << (qw - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/fft_top_div_seq_step.sv
// -----------------------------------------------------------------------------
// fft_top_div_step
// One combinational restoring radix-2 division iteration on magnitudes.
//
// Ports:
//   i_rem    [DW:0]   current partial remainder
//   i_bit             next dividend bit (MSB first)
//   i_dvsr   [DW-1:0] divisor magnitude
//   o_rem    [DW:0]   next partial remainder
//   o_qbit            quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module fft_top_div_step
  import fft_top_div_pkg::*;
#(
  parameter int DW = DEF_DIVISOR_WIDTH
) (
  input  logic [DW:0]   i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_dvsr,
  output logic [DW:0]   o_rem,
  output logic          o_qbit
);

  // One extra bit of headroom keeps the trial subtraction exact even when
  // the incoming remainder already uses its top bit (only possible on the
  // overflow path, whose result is discarded by the fixup anyway).
  logic [DW+1:0] w_shift;
  logic [DW+1:0] w_diff;
  logic          w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {2'b00, i_dvsr});
  assign w_diff  = w_shift - {2'b00, i_dvsr};

  assign o_qbit = w_ge;
  assign o_rem  = (DW+1)'(w_ge ? w_diff : w_shift);

endmodule

// File: rtl/fft_top_div_seq.sv
// -----------------------------------------------------------------------------
// fft_top_div_seq
// Sequential signed divider: 35-bit signed dividend / 15-bit signed divisor
// -> 20-bit signed quotient plus 15-bit signed remainder. One restoring step
// per clock-enabled cycle; fixed latency of QUOTIENT_WIDTH enabled edges from
// accept to result, regardless of divide-by-zero or overflow.
//
// Handshake: a transfer happens on a rising clk edge where ce is high and
// both valid and ready are high. din_ready is high only in IDLE, dout_valid
// only in DONE; both are decoded from the state register alone. Result
// outputs hold their value from load until the next result loads.
//
// Ports:
//   clk, reset (async, active high), ce (global clock enable)
//   din_valid / din_ready, dividend, divisor  : operand input
//   dout_valid / dout_ready                   : result output handshake
//   quotient, remainder, ovf, dbz             : registered result
//   dbg_state                                 : current FSM state
// -----------------------------------------------------------------------------
module fft_top_div_seq
  import fft_top_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,  // = QUOTIENT_WIDTH + DIVISOR_WIDTH
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int QUOTIENT_WIDTH = DEF_QUOTIENT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             din_valid,
  output logic                             din_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic signed [QUOTIENT_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             ovf,
  output logic                             dbz,
  output logic [1:0]                       dbg_state
);

  localparam int NW = DIVIDEND_WIDTH;
  localparam int DW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(QW + 1);

  localparam logic [CW-1:0] L_LAST   = CW'(QW - 1);
  localparam logic [63:0]   L_QMAX64 = qmax(QW);
  localparam logic [63:0]   L_QMIN64 = qmin(QW);
  localparam logic [QW-1:0] L_QMAX   = L_QMAX64[QW-1:0];
  localparam logic [QW-1:0] L_QMIN   = L_QMIN64[QW-1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_t r_state;
  div_state_t w_next_state;

  logic [CW-1:0] r_cnt;
  logic [DW:0]   r_rem;       // partial remainder
  logic [QW-1:0] r_dvd_lo;    // remaining dividend bits, consumed MSB first
  logic [QW-2:0] r_q;         // quotient magnitude bits collected so far
  logic [DW-1:0] r_dvsr_mag;
  logic          r_dvd_neg;
  logic          r_dvsr_neg;
  logic          r_ovf_pre;
  logic          r_dbz_pre;

  logic [QW-1:0] r_quotient;
  logic [DW-1:0] r_remainder;
  logic          r_ovf;
  logic          r_dbz;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  logic          w_dvd_neg;
  logic          w_dvsr_neg;
  logic [NW-1:0] w_dvd_mag;
  logic [DW-1:0] w_dvsr_mag;
  logic          w_ovf_pre;
  logic          w_accept;

  assign w_dvd_neg  = dividend[NW-1];
  assign w_dvsr_neg = divisor[DW-1];
  // Negating the most negative value wraps back to itself, which is exactly
  // its magnitude when read as unsigned.
  assign w_dvd_mag  = w_dvd_neg  ? -dividend : dividend;
  assign w_dvsr_mag = w_dvsr_neg ? -divisor  : divisor;

  // The upper DW dividend bits seed the partial remainder. If they already
  // reach the divisor, the quotient needs more than QW bits.
  assign w_ovf_pre = (w_dvd_mag[NW-1:QW] >= w_dvsr_mag);

  assign din_ready  = (r_state == ST_IDLE);
  assign dout_valid = (r_state == ST_DONE);
  assign w_accept   = din_valid & din_ready;

  // ---------------------------------------------------------------------------
  // Iteration
  // ---------------------------------------------------------------------------
  logic [DW:0]   w_step_rem;
  logic          w_step_qbit;
  logic [QW-1:0] w_q_mag;
  logic [DW-1:0] w_r_mag;

  fft_top_div_step #(
    .DW (DW)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd_lo[QW-1]),
    .i_dvsr (r_dvsr_mag),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_qbit)
  );

  // Values as they will be after the current step; on the last step these
  // are the final magnitudes fed straight into the fixup.
  assign w_q_mag = {r_q, w_step_qbit};
  assign w_r_mag = w_step_rem[DW-1:0];

  // ---------------------------------------------------------------------------
  // Sign fixup and saturation
  // ---------------------------------------------------------------------------
  logic          w_res_neg;
  logic          w_range_ovf;
  logic [QW-1:0] w_fix_q;
  logic [DW-1:0] w_fix_r;
  logic          w_fix_ovf;
  logic          w_fix_dbz;

  assign w_res_neg = r_dvd_neg ^ r_dvsr_neg;
  // A negative result may reach magnitude 2^(QW-1); a positive one may not.
  assign w_range_ovf = w_res_neg ? (w_q_mag > L_QMIN) : w_q_mag[QW-1];

  always_comb begin
    w_fix_q   = w_res_neg ? -w_q_mag : w_q_mag;
    w_fix_r   = r_dvd_neg ? -w_r_mag : w_r_mag;
    w_fix_ovf = 1'b0;
    w_fix_dbz = 1'b0;
    if (r_dbz_pre) begin
      // Saturate by dividend sign: the divisor carries no useful sign here.
      w_fix_q   = r_dvd_neg ? L_QMIN : L_QMAX;
      w_fix_r   = '0;
      w_fix_dbz = 1'b1;
    end else if (r_ovf_pre || w_range_ovf) begin
      w_fix_q   = w_res_neg ? L_QMIN : L_QMAX;
      w_fix_r   = '0;
      w_fix_ovf = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (ce && din_valid)           w_next_state = ST_CALC;
      ST_CALC: if (ce && (r_cnt == L_LAST))   w_next_state = ST_DONE;
      ST_DONE: if (ce && dout_ready)          w_next_state = ST_IDLE;
      default:                                w_next_state = ST_IDLE;
    endcase
  end

  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd_lo    <= '0;
      r_q         <= '0;
      r_dvsr_mag  <= '0;
      r_dvd_neg   <= 1'b0;
      r_dvsr_neg  <= 1'b0;
      r_ovf_pre   <= 1'b0;
      r_dbz_pre   <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else if (ce) begin
      if (w_accept) begin
        r_cnt      <= '0;
        r_rem      <= {1'b0, w_dvd_mag[NW-1:QW]};
        r_dvd_lo   <= w_dvd_mag[QW-1:0];
        r_q        <= '0;
        r_dvsr_mag <= w_dvsr_mag;
        r_dvd_neg  <= w_dvd_neg;
        r_dvsr_neg <= w_dvsr_neg;
        r_ovf_pre  <= w_ovf_pre;
        r_dbz_pre  <= (divisor == '0);
      end else if (r_state == ST_CALC) begin
        r_cnt    <= r_cnt + CW'(1);
        r_rem    <= w_step_rem;
        r_dvd_lo <= {r_dvd_lo[QW-2:0], 1'b0};
        r_q      <= w_q_mag[QW-2:0];
        if (r_cnt == L_LAST) begin
          r_quotient  <= w_fix_q;
          r_remainder <= w_fix_r;
          r_ovf       <= w_fix_ovf;
          r_dbz       <= w_fix_dbz;
        end
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_fft_top_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fft_top_div_seq
// Bench for the sequential signed divider. Expected results come from an
// integer-arithmetic reference model of the division and saturation rules.
// -----------------------------------------------------------------------------
module tb_fft_top_div_seq;

  localparam int NW = 35;
  localparam int DW = 15;
  localparam int QW = 20;
  localparam int RW = 2 + DW + QW;  // {dbz, ovf, remainder, quotient}
  localparam longint QMAX = 524287;
  localparam longint QMIN = -524288;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ce;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [NW-1:0] dividend;
  logic signed [DW-1:0] divisor;
  logic                 dout_valid;
  logic                 dout_ready;
  logic signed [QW-1:0] quotient;
  logic signed [DW-1:0] remainder;
  logic                 ovf;
  logic                 dbz;
  logic [1:0]           dbg_state;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];

  fft_top_div_seq dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .ovf        (ovf),
    .dbz        (dbz),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: truncating division on magnitudes, remainder follows the
  // dividend sign, saturation when the quotient does not fit QW signed bits.
  // ---------------------------------------------------------------------------
  function automatic logic [RW-1:0] model(input longint n, input longint d);
    longint mn, md, qm, rm, q, r;
    logic   neg, fo, fz;
    fz = 1'b0;
    fo = 1'b0;
    if (d == 0) begin
      q  = (n >= 0) ? QMAX : QMIN;
      r  = 0;
      fz = 1'b1;
    end else begin
      mn  = (n < 0) ? -n : n;
      md  = (d < 0) ? -d : d;
      qm  = mn / md;
      rm  = mn % md;
      neg = (n < 0) != (d < 0);
      if ((!neg && qm > QMAX) || (neg && qm > -QMIN)) begin
        fo = 1'b1;
        q  = neg ? QMIN : QMAX;
        r  = 0;
      end else begin
        q = neg ? -qm : qm;
        r = (n < 0) ? -rm : rm;
      end
    end
    model = {fz, fo, r[DW-1:0], q[QW-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input longint n, input longint d);
    int guard;
    guard = 0;
    while (!din_ready && guard < 100) begin
      cyc();
      guard++;
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready got=%0b want=1", din_ready);
    end
    dividend  = n[NW-1:0];
    divisor   = d[DW-1:0];
    din_valid = 1'b1;
    ce        = 1'b1;
    cyc();
    din_valid = 1'b0;
    exp_q.push_back(model(n, d));
  endtask

  // Runs until dout_valid, optionally dropping ce at random; reports how many
  // ce-enabled edges elapsed since the accept.
  task automatic wait_done(input int gap_pct, output int en_edges, output int gaps);
    int n_cyc;
    n_cyc    = 0;
    en_edges = 0;
    gaps     = 0;
    while (!dout_valid && n_cyc < 400) begin
      ce = ($urandom_range(0, 99) < gap_pct) ? 1'b0 : 1'b1;
      if (ce) en_edges++;
      else    gaps++;
      cyc();
      n_cyc++;
    end
    ce = 1'b1;
  endtask

  task automatic release_out();
    ce         = 1'b1;
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
  endtask

  task automatic gen_operands(output longint n, output longint d);
    int                   mode;
    longint               md;
    logic signed [NW-1:0] sb;
    mode = $urandom_range(0, 9);
    d    = longint'($urandom_range(0, 32767)) - 16384;
    sb   = NW'({$urandom(), $urandom()});
    if (mode < 7) begin
      if (d == 0) d = 3;
      md = (d < 0) ? -d : d;
      n  = longint'($urandom_range(0, 1048575)) - 524288;
      n  = n * d + longint'($urandom_range(0, 32'(md - 1)));
    end else if (mode < 9) begin
      n = sb;
    end else begin
      d = 0;
      n = sb;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset      = 1'b1;
    ce         = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) cyc();
    reset = 1'b0;
    ce    = 1'b1;
    cyc();
    checks++; if (din_ready !== 1'b1)  begin errors++; $display("FAIL reset_din_ready got=%0b want=1", din_ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%0b want=0", dout_valid); end
    checks++; if (quotient !== '0)     begin errors++; $display("FAIL reset_quotient got=%0d want=0", quotient); end
    checks++; if (remainder !== '0)    begin errors++; $display("FAIL reset_remainder got=%0d want=0", remainder); end
    checks++; if ({ovf, dbz} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {ovf, dbz}); end
    checks++; if (dbg_state !== 2'd0)  begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
  endtask

  task automatic test_directed();
    longint        tn[10];
    longint        td[10];
    int            e, g;
    logic [RW-1:0] got, exp;
    tn = '{1000, -1000, 1000, -1000, 5, -5, 64'sd1 << 30, 64'sd1 << 19,
           -(64'sd1 << 19), -(64'sd1 << 34)};
    td = '{7, 7, -7, -7, 0, 0, 1, 1, 1, -16384};
    for (int i = 0; i < 10; i++) begin
      start_op(tn[i], td[i]);
      wait_done(0, e, g);
      checks++;
      if (!(dout_valid === 1'b1 && e == QW)) begin
        errors++;
        $display("FAIL dir_latency[%0d] got=%0d edges valid=%0b want=%0d", i, e, dout_valid, QW);
      end
      got = {dbz, ovf, remainder, quotient};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL dir_result[%0d] %0d/%0d got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                 i, tn[i], td[i], quotient, remainder, ovf, dbz,
                 $signed(exp[QW-1:0]), $signed(exp[QW+DW-1:QW]), exp[RW-2], exp[RW-1]);
      end
      release_out();
      checks++;
      if ({dout_valid, din_ready} !== 2'b01) begin
        errors++;
        $display("FAIL dir_release[%0d] got valid/ready=%b want=01", i, {dout_valid, din_ready});
      end
    end
  endtask

  task automatic test_random_gaps();
    longint        n, d;
    int            e, g;
    logic [RW-1:0] got, exp;
    for (int i = 0; i < 30; i++) begin
      gen_operands(n, d);
      start_op(n, d);
      wait_done(30, e, g);
      checks++;
      if (!(dout_valid === 1'b1 && e == QW)) begin
        errors++;
        $display("FAIL gap_latency[%0d] got=%0d enabled edges (gaps=%0d) valid=%0b want=%0d",
                 i, e, g, dout_valid, QW);
      end
      got = {dbz, ovf, remainder, quotient};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gap_result[%0d] %0d/%0d got=%h want=%h", i, n, d, got, exp);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int            e, g;
    logic [RW-1:0] got, exp, held;
    start_op(-123456789, 1234);
    wait_done(0, e, g);
    got = {dbz, ovf, remainder, quotient};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_result got=%h want=%h", got, exp);
    end
    held = exp;
    for (int i = 0; i < 10; i++) begin
      dout_ready = 1'b0;
      din_valid  = ~din_valid;
      dividend   = NW'({$urandom(), $urandom()});
      divisor    = DW'($urandom());
      cyc();
      checks++;
      if ({dout_valid, din_ready, dbz, ovf, remainder, quotient} !== {2'b10, held}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got=%b_%h want=10_%h", i, {dout_valid, din_ready},
                 {dbz, ovf, remainder, quotient}, held);
      end
    end
    din_valid = 1'b0;
    // A ready pulse while ce is low must not complete the handshake.
    ce         = 1'b0;
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    ce         = 1'b1;
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_ce_low got valid=%0b want=1", dout_valid);
    end
    release_out();
    cyc();
    checks++;
    if ({dout_valid, din_ready, dbz, ovf, remainder, quotient} !== {2'b01, held}) begin
      errors++;
      $display("FAIL bp_after got=%b_%h want=01_%h", {dout_valid, din_ready},
               {dbz, ovf, remainder, quotient}, held);
    end
  endtask

  task automatic test_reset_mid();
    int            e, g;
    logic [RW-1:0] got, exp;
    start_op(777777, 55);
    repeat (7) cyc();
    void'(exp_q.pop_back());  // this operation is abandoned by the reset
    reset = 1'b1;
    #1;
    checks++;
    if ({din_ready, dout_valid, ovf, dbz} !== 4'b1000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL mid_reset got ready=%0b valid=%0b q=%0d r=%0d ovf=%0b dbz=%0b want 1 0 0 0 0 0",
               din_ready, dout_valid, quotient, remainder, ovf, dbz);
    end
    cyc();
    reset = 1'b0;
    cyc();
    start_op(123456, -321);
    wait_done(0, e, g);
    checks++;
    if (!(dout_valid === 1'b1 && e == QW)) begin
      errors++;
      $display("FAIL mid_latency got=%0d want=%0d", e, QW);
    end
    got = {dbz, ovf, remainder, quotient};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_result got q=%0d r=%0d want q=%0d r=%0d", quotient, remainder,
               $signed(exp[QW-1:0]), $signed(exp[QW+DW-1:QW]));
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    longint        n, d;
    int            e, g;
    logic [RW-1:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      gen_operands(n, d);
      start_op(n, d);
      wait_done(0, e, g);
      got = {dbz, ovf, remainder, quotient};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || e != QW) begin
        errors++;
        $display("FAIL b2b[%0d] %0d/%0d got=%h edges=%0d want=%h edges=%0d", i, n, d, got, e, exp, QW);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_gaps();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_top_div_seq.md
# fft_top_div_seq

Sequential signed divider, the inverse of the FFT datapath's pipelined signed multiplier: it divides a 35-bit signed product-width value by a 15-bit signed coefficient to recover a 20-bit signed sample. It runs one restoring radix-2 iteration per clock-enabled cycle behind a valid/ready handshake. It sits beside the multiplier stages in `fft_top`, where it is used for gain normalisation and for unscaling twiddle products.

## Interface
Parameters:
- `DIVIDEND_WIDTH`, 35: signed dividend width; must equal `QUOTIENT_WIDTH + DIVISOR_WIDTH`.
- `DIVISOR_WIDTH`, 15: signed divisor width; also the remainder width.
- `QUOTIENT_WIDTH`, 20: signed quotient width; also the iteration count.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ce` in 1: global clock enable. When low, all state and outputs are frozen and no handshake completes.
- `din_valid` in 1: dividend/divisor pair valid.
- `din_ready` out 1: block can accept a pair; high only in IDLE.
- `dividend` in `DIVIDEND_WIDTH`: signed dividend.
- `divisor` in `DIVISOR_WIDTH`: signed divisor.
- `dout_valid` out 1: result valid; high only in DONE.
- `dout_ready` in 1: downstream accepts the result.
- `quotient` out `QUOTIENT_WIDTH`: signed quotient, registered.
- `remainder` out `DIVISOR_WIDTH`: signed remainder, registered.
- `ovf` out 1: quotient saturated because the true result does not fit.
- `dbz` out 1: divisor was zero.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE → CALC** on a ce-enabled edge with `din_valid & din_ready`.
  - Latch the operand signs and magnitudes. The dividend magnitude is `DIVIDEND_WIDTH` bits unsigned; the divisor magnitude is `DIVISOR_WIDTH` bits unsigned.
  - Latch `ovf_pre = (|dividend| >> QUOTIENT_WIDTH) >= |divisor|` and `dbz_pre = (divisor == 0)`.
  - Clear the iteration counter.
- **CALC:** one restoring step per ce-enabled edge, MSB first.
  - The partial remainder is `DIVISOR_WIDTH+1` bits. Shift in the next dividend bit, trial-subtract `|divisor|`, keep the result if it is non-negative, and shift the quotient bit in.
  - Move to DONE after exactly `QUOTIENT_WIDTH` steps. The last step's edge also performs fixup and loads the output registers.
- **Fixup rules:**
  - The quotient truncates toward zero. Its sign is the XOR of the operand signs.
  - The remainder takes the dividend's sign, so `dividend = q*divisor + r` holds when neither flag is set.
  - If `dbz_pre`: `quotient` = +2^(QW-1)-1 when dividend ≥ 0, else -2^(QW-1). `remainder` = 0, `dbz` = 1, `ovf` = 0.
  - Else if `ovf_pre`, or the magnitude exceeds the signed range (positive > 2^(QW-1)-1, negative > 2^(QW-1)): saturate `quotient` the same way by result sign, `remainder` = 0, `ovf` = 1.
- **DONE → IDLE** on a ce-enabled edge with `dout_ready`. The output registers keep their values until the next result loads.
- No overlap: `din_ready` is 0 in CALC and DONE, so no accept happens in the same cycle as a `dout` handshake.
- **Reset:** asynchronous, so a reset mid-CALC or in DONE returns to IDLE immediately and the in-flight operation is discarded.

## Timing
- **Reset values:** state IDLE, `din_ready` = 1, `dout_valid` = 0, `quotient` = 0, `remainder` = 0, `ovf` = 0, `dbz` = 0, counter 0.
- **Latency:** with the accept at ce-enabled edge k, `dout_valid` rises after ce-enabled edge k+`QUOTIENT_WIDTH` (20 by default).
  - Latency is constant, including the dbz and ovf cases.
  - Cycles with `ce` low stretch the latency 1:1.
- **Throughput:** one operation per `QUOTIENT_WIDTH`+2 cycles at best (accept edge, 20 CALC edges, one DONE handshake edge).
- **Backpressure:** `dout_valid`, `quotient`, `remainder`, `ovf` and `dbz` stay stable in DONE until the handshake completes.
- **`ce` low in DONE:** a `dout_ready` pulse is ignored.
- `din_ready` and `dout_valid` are decoded from the state register only, with no input-to-output combinational path.

## Structure
- **Package `fft_top_div_pkg`:** state enum (IDLE/CALC/DONE), default width localparams, and the saturation constants `QMAX`/`QMIN` as functions of the width.
- **Sub-module `fft_top_div_step`:** combinational single restoring iteration. Inputs are the partial remainder, the next dividend bit and the divisor magnitude; outputs are the next partial remainder and the quotient bit. The top level holds the FSM, counter, sign/magnitude capture and fixup.

## Test plan
- 1000 / 7 → `quotient` = 142, `remainder` = 6, flags 0, `dout_valid` at accept+20 edges.
- -1000 / 7 → -142, r = -6; 1000 / -7 → -142, r = 6; -1000 / -7 → 142, r = -6.
- 5 / 0 → `quotient` = 524287, `dbz` = 1. -5 / 0 → -524288, `dbz` = 1. Latency is still 20.
- 2^30 / 1 → 524287, `ovf` = 1. 2^19 / 1 → 524287, `ovf` = 1. -2^19 / 1 → -524288, `ovf` = 0. -2^34 / -2^14 → 2^20, saturated 524287, `ovf` = 1.
- Hold `dout_ready` = 0 for 10 cycles in DONE, toggling `din_valid` meanwhile → outputs stable, no accept. Random `ce` gaps during CALC → latency grows by exactly the number of `ce`-low cycles.
- Assert `reset` at CALC step 7 → all outputs reach their reset values immediately. The next operation, 123456 / -321 → -384, r = 192, completes correctly.
